// File: rtl/rom_writer_if.sv
// Byte-stream handshake between the host link (UART receiver) and the ROM loader.
interface rom_writer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/rom_writer.sv
// Loads a length-prefixed little-endian image into the instruction ROM's BRAM write port.
// Optional trailer checksum verification when ROM_WRITER_CHECKSUM_EN is defined.
module rom_writer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 16384
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          start,
  rom_writer_if.slave   s,
  output logic          ena,
  output logic          wea,
  output logic [31:0]   addra,
  output logic [31:0]   dina,
  output logic          busy,
  output logic          done,
  output logic          error
);

`ifdef ROM_WRITER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR} state_t;
  localparam state_t EOD = CSUM;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERROR} state_t;
  localparam state_t EOD = DONE;
`endif

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  state_t      r_state, w_state_nx;
  logic [1:0]  r_cnt;
  logic [31:0] r_idx;
  logic [31:0] r_addra, r_dina;
  logic [31:0] r_shift, r_len;
`ifdef ROM_WRITER_CHECKSUM_EN
  logic [31:0] r_sum;
`endif

  logic        w_ready, w_accept, w_last_byte, w_launch;
  logic [31:0] w_shift, w_idx_inc;

  // Bytes arrive LSB first, so each new byte enters at the top of the shifter.
  assign w_shift     = {s.s_data, r_shift[31:8]};
  assign w_accept    = s.s_valid & w_ready;
  assign w_last_byte = w_accept & (r_cnt == 2'd3);
  assign w_idx_inc   = r_idx + 32'd1;
  assign w_launch    = start & ~busy;
  assign s.s_ready   = w_ready;
  assign addra       = r_addra;
  assign dina        = r_dina;

  always_comb begin
    w_state_nx = r_state;
    w_ready    = 1'b0;
    wea        = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: if (start) w_state_nx = LEN;
      LEN: begin
        w_ready = 1'b1;
        if (w_last_byte) begin
          if (w_shift > DEPTH_L)      w_state_nx = ERROR;
          else if (w_shift == 32'd0)  w_state_nx = EOD;
          else                        w_state_nx = DATA;
        end
      end
      DATA: begin
        w_ready = 1'b1;
        if (w_last_byte) w_state_nx = WRITE;
      end
      WRITE: begin
        wea        = 1'b1;
        w_state_nx = (w_idx_inc == r_len) ? EOD : DATA;
      end
`ifdef ROM_WRITER_CHECKSUM_EN
      CSUM: begin
        w_ready = 1'b1;
        if (w_last_byte) w_state_nx = (w_shift == r_sum) ? DONE : ERROR;
      end
`endif
      default: w_state_nx = IDLE;
    endcase
    ena   = wea;
    busy  = !(r_state == IDLE || r_state == DONE || r_state == ERROR);
    done  = (r_state == DONE);
    error = (r_state == ERROR);
  end

  // Control state, write port registers and counters
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_idx   <= 32'd0;
      r_addra <= 32'd0;
      r_dina  <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      if (w_launch) begin
        r_cnt <= 2'd0;
        r_idx <= 32'd0;
      end else begin
        if (w_accept) r_cnt <= r_cnt + 2'd1;
        if (r_state == DATA && w_last_byte) begin
          r_addra <= BASE_ADDR + {r_idx[29:0], 2'b00};
          r_dina  <= w_shift;
        end
        if (r_state == WRITE) r_idx <= w_idx_inc;
      end
    end
  end

  // Assembly datapath: no reset, every session overwrites before use
  always_ff @(posedge clka) begin
    if (w_accept) r_shift <= w_shift;
    if (r_state == LEN && w_last_byte) r_len <= w_shift;
`ifdef ROM_WRITER_CHECKSUM_EN
    if (w_launch) r_sum <= 32'd0;
    else if (r_state == DATA && w_last_byte) r_sum <= r_sum + w_shift;
`endif
  end

endmodule

// File: tb/tb_rom_writer.sv
// Randomized scoreboard bench for rom_writer; honours ROM_WRITER_CHECKSUM_EN.
module tb_rom_writer;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 16384;
`ifdef ROM_WRITER_CHECKSUM_EN
  localparam int TRL = 4;
`else
  localparam int TRL = 0;
`endif

  logic        clka = 1'b0;
  logic        rsta, start;
  logic        ena, wea, busy, done, error;
  logic [31:0] addra, dina;

  rom_writer_if sif();

  rom_writer #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clka(clka), .rsta(rsta), .start(start), .s(sif),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clka = ~clka;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] sb_addr[$];
  logic [31:0] sb_data[$];
  logic [31:0] g_words[$];
  logic        prev_wea = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard
  always @(negedge clka) begin
    if (rsta === 1'b0) begin
      chk("ena_eq_wea", {31'd0, ena}, {31'd0, wea});
      if (wea === 1'b1) begin
        if (sb_addr.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write: addra %h dina %h, no write required", addra, dina);
        end else begin
          chk("wr_addr", addra, sb_addr.pop_front());
          chk("wr_data", dina, sb_data.pop_front());
        end
        chk("s_ready_in_write", {31'd0, sif.s_ready}, 32'd0);
        chk("wea_single_pulse", {31'd0, prev_wea}, 32'd0);
      end
      prev_wea = wea;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, {31'd0, sif.s_ready}, 32'd0);
    chk({tag, "_ena"},     {31'd0, ena},   32'd0);
    chk({tag, "_wea"},     {31'd0, wea},   32'd0);
    chk({tag, "_busy"},    {31'd0, busy},  32'd0);
    chk({tag, "_done"},    {31'd0, done},  32'd0);
    chk({tag, "_error"},   {31'd0, error}, 32'd0);
    chk({tag, "_addra"},   addra, 32'd0);
    chk({tag, "_dina"},    dina,  32'd0);
  endtask

  // One load session. stop_after >= 0 sends only that many bytes and returns mid-session.
  task automatic session(input logic [31:0] n, input int gapmax, input bit zero_trailer,
                         input int stop_after, input int mid_start_at);
    logic [7:0]  bs[$];
    logic [31:0] sum, tr, w;
    bit          over, exp_err, r;
    int          nw, len, lim, t, gap;
    over = (n > 32'(DEPTH));
    nw   = over ? 0 : int'(n);
    sum  = 32'd0;
    for (int k = 0; k < 4; k++) bs.push_back(n[8*k +: 8]);
    for (int i = 0; i < nw; i++) begin
      w = g_words[i];
      sum += w;
      for (int k = 0; k < 4; k++) bs.push_back(w[8*k +: 8]);
    end
    tr = zero_trailer ? 32'd0 : sum;
    for (int k = 0; k < 4; k++) bs.push_back(tr[8*k +: 8]);
    len     = over ? 4 : 4 + 4 * nw + TRL;
    exp_err = over || (TRL != 0 && tr != sum);
    lim     = (stop_after >= 0) ? stop_after : len;
    for (int i = 0; i < nw; i++)
      if (4 + 4 * i + 3 < lim) begin
        sb_addr.push_back(BASE + 32'(4 * i));
        sb_data.push_back(g_words[i]);
      end

    start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);

    for (int i = 0; i < lim; i++) begin
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      sif.s_valid = 1'b0;
      repeat (gap) begin @(posedge clka); #1; end
      sif.s_data  = bs[i];
      sif.s_valid = 1'b1;
      if (i == mid_start_at) start = 1'b1;
      t = 0;
      do begin
        r = sif.s_ready;
        @(posedge clka); #1;
        start = 1'b0;
        t++;
      end while (!r && t < 50);
      if (!r) begin
        n_vec++;
        n_bad++;
        $display("FAIL byte_accept_timeout: byte %0d not accepted in 50 cycles", i);
        sif.s_valid = 1'b0;
        return;
      end
      if (i >= 4 && i < 4 + 4 * nw && ((i - 4) % 4) == 3)
        chk("wea_latency", {31'd0, wea}, 32'd1);
    end
    sif.s_valid = 1'b0;
    if (stop_after >= 0) return;

    if (!over && nw > 0 && TRL == 0) begin @(posedge clka); #1; end
    chk("end_done",    {31'd0, done},  {31'd0, !exp_err});
    chk("end_error",   {31'd0, error}, {31'd0, exp_err});
    chk("end_busy",    {31'd0, busy},  32'd0);
    chk("end_s_ready", {31'd0, sif.s_ready}, 32'd0);
    @(posedge clka); #1;
    chk("writes_left", sb_addr.size(), 32'd0);
  endtask

  task automatic fill_random(input int n);
    g_words.delete();
    for (int i = 0; i < n; i++) g_words.push_back($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsta = 1'b1; start = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = 8'h00;
    repeat (3) @(posedge clka);
    #1 rsta = 1'b0;
    check_reset_outputs("reset");

    g_words.delete();
    g_words.push_back(32'h1234_5678);
    g_words.push_back(32'hDEAD_BEEF);
    session(32'd2, 0, 1'b0, -1, -1);
    session(32'd0, 0, 1'b0, -1, -1);
    session(32'(DEPTH + 1), 0, 1'b0, -1, -1);
    session(32'd2, 3, 1'b0, -1, -1);
    if (TRL != 0) session(32'd2, 0, 1'b1, -1, -1);

    fill_random(3);
    session(32'd3, 0, 1'b0, 10, -1);
    rsta = 1'b1;
    @(posedge clka); #1;
    rsta = 1'b0;
    check_reset_outputs("mid_reset");
    chk("mid_reset_writes", sb_addr.size(), 32'd0);
    sb_addr.delete(); sb_data.delete();

    fill_random(4);
    session(32'd4, 1, 1'b0, -1, 9);

    for (int k = 0; k < 12; k++) begin
      int n;
      n = int'($urandom_range(0, 6));
      fill_random(n);
      session(32'(n), 3, $urandom_range(0, 1) == 1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rom_writer.md
# rom_writer

Loader that fills the instruction ROM's block RAM from a byte stream, the write side of the `clka/ena/addra/douta` ROM port the CPU fetches from. It accepts a length-prefixed little-endian image over a valid/ready byte interface, assembles 32-bit words, and issues one BRAM write per word at byte addresses stepping by 4 from `BASE_ADDR`. It sits between the host byte link (UART receiver) and the ROM's write port, and holds the CPU in reset through `busy`.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be 4-aligned.
- `DEPTH_WORDS`, 16384: ROM capacity in 32-bit words; larger images are rejected.
- `clka`  in  1  clock; all logic on rising edge.
- `rsta`  in  1  reset; one clock, reset synchronous and active-high.
- `start`  in  1  one-cycle pulse; begins a load session from IDLE, DONE or ERROR; ignored while `busy`.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  byte accepted on an edge where `s_valid & s_ready`.
- `ena`  out  1  BRAM enable; equals `wea`.
- `wea`  out  1  BRAM write strobe, one cycle per word.
- `addra`  out  32  BRAM byte address.
- `dina`  out  32  BRAM write data.
- `busy`  out  1  session in progress.
- `done`  out  1  image loaded successfully; held until next `start` or reset.
- `error`  out  1  session aborted; held until next `start` or reset.

## Operation
- Stream format: 4-byte word count N (LSB first), then N words of 4 bytes each (LSB first).
- States: IDLE, LEN, DATA, WRITE, (CSUM), DONE, ERROR.
- IDLE/DONE/ERROR + `start` -> LEN; clears `done`, `error`, byte counter, word index; `busy`=1.
- LEN: collect 4 bytes into N. After the 4th: N > `DEPTH_WORDS` -> ERROR; N = 0 -> end-of-data; else -> DATA.
- DATA: collect 4 bytes into a word register; after the 4th -> WRITE.
- WRITE: `wea`=`ena`=1, `addra` = `BASE_ADDR` + 4*index, `dina` = assembled word; index increments; index = N -> end-of-data, else -> DATA.
- End-of-data: -> DONE (or CSUM when configured).
- DONE: `done`=1, `busy`=0. ERROR: `error`=1, `busy`=0. No writes in either.
- `addra` arithmetic is 32-bit modulo 2^32; the `DEPTH_WORDS` check keeps it inside the ROM.
- `start` while `busy`: ignored, no state change.
- `rsta` mid-session: returns to IDLE at the next edge; words already written stay in memory (no rollback).

## Timing
- Reset values: `s_ready`, `ena`, `wea`, `busy`, `done`, `error` = 0; `addra`, `dina` = 0; state IDLE.
- `s_ready` = 1 exactly in LEN, DATA and CSUM; 0 in WRITE, so at most one byte every cycle except the write cycle.
- `busy` rises the edge after `start`.
- Write latency: `wea` asserted in the cycle immediately after the edge that accepted a word's 4th byte.
- `done`/`error` assert the cycle after the final WRITE, or the cycle after the edge accepting the last header or checksum byte.
- `addra`/`dina` hold their last values outside WRITE; `wea` is a single-cycle pulse.
- Gaps on `s_valid` stall the FSM with no effect on results.

## Configuration
- `ROM_WRITER_CHECKSUM_EN` defined: after the N data words the stream carries a 4-byte trailer (LSB first), collected in CSUM. It is compared with the running sum of all data words, modulo 2^32. Match -> DONE, mismatch -> ERROR. Data words are still written before the check.
- Undefined: no CSUM state, no trailer; end-of-data goes directly to DONE.

## Test plan
- Reset, `start`, bytes 02 00 00 00 78 56 34 12 EF BE AD DE, `s_valid` held high. Required response: writes (`addra`=0x0, `dina`=0x12345678) then (0x4, 0xDEADBEEF), exactly 2 `wea` pulses, then `done`=1, `busy`=0.
- N=0 (00 00 00 00). Required response: no `wea`; `done`=1 one cycle after the 4th byte accepted (checksum build: after trailer 00 00 00 00).
- N=`DEPTH_WORDS`+1. Required response: `error`=1 one cycle after the header; no `wea`; `s_ready`=0.
- Same stream as the first scenario with random 0-3 cycle `s_valid` gaps. Required response: identical write sequence; `s_ready`=0 in each WRITE cycle.
- Checksum build, first scenario plus trailer 67 15 E2 F0 -> `done`=1. Same with trailer 00 00 00 00 -> both words written, then `error`=1.
- `rsta` pulsed after the 6th data byte. Required response: all outputs at reset values next cycle. Then `start` plus a full stream completes normally; `start` pulsed mid-session is ignored.
